// File: rtl/orb_frame_packer.sv
// Round-robin packer that drains fast (burst) and slow (addressed) FIFOs
// into a frame memory, one word per LOAD/WRITE/GAP triplet, with a guard gap.
module orb_frame_packer #(
  parameter int NF    = 2,
  parameter int NS    = 2,
  parameter int DW    = 12,
  parameter int AW    = 11,
  parameter int UW    = 5,
  parameter int WORDS = 16,
  parameter int FRAME = 32,
  parameter int PKTS  = 64,
  parameter int GUARD = 32,
  localparam int NSP  = (NS > 0) ? NS : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NF*UW-1:0]  f_usedw,
  input  logic [NF*DW-1:0]  f_data,
  output logic [NF-1:0]     f_rdack,
  input  logic [NSP-1:0]    s_empty,
  input  logic [NSP*AW-1:0] s_addr,
  input  logic [NSP*DW-1:0] s_data,
  output logic [NSP-1:0]    s_rdack,
  output logic [AW-1:0]     wAddr,
  output logic [DW-1:0]     orbWord,
  output logic              WE,
  output logic              busy
);

  // state | meaning
  // IDLE  | round-robin arbitration over all requesters
  // LOAD  | pop granted FIFO head, register address and data
  // WRITE | WE high for one cycle
  // GAP   | WE low; next burst word or finish transaction
  // GUARD | idle spacing after every transaction
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_GUARD = 3'd4;

  localparam int NR  = NF + NS;
  localparam int IW  = (NR > 1) ? $clog2(NR) : 1;
  localparam int KW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PW  = (PKTS > 1) ? $clog2(PKTS) : 1;
  localparam int GCW = $clog2(GUARD + 1);

  logic [2:0]     state;
  logic [IW-1:0]  grant;
  logic [IW-1:0]  rrPtr;
  logic [KW-1:0]  wordIdx;
  logic [GCW-1:0] guardCnt;
  logic [PW-1:0]  slot [NF];

  logic [NR-1:0]  req;
  logic           found;
  logic [IW-1:0]  pick;
  int             j;

  logic           isFast;
  logic [DW-1:0]  headData;
  logic [AW-1:0]  fastAddr;
  logic [AW-1:0]  sAddrSel;
  logic [PW-1:0]  curSlot;

  always_comb begin
    req = '0;
    for (int c = 0; c < NF; c++) req[c] = int'(f_usedw[c*UW +: UW]) >= WORDS;
    for (int s = 0; s < NS; s++) req[NF+s] = !s_empty[s];
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int i = 0; i < NR; i++) begin
      j = int'(rrPtr) + i;
      if (j >= NR) j = j - NR;
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  always_comb begin
    isFast   = int'(grant) < NF;
    headData = '0;
    curSlot  = '0;
    sAddrSel = '0;
    for (int c = 0; c < NF; c++) begin
      if (int'(grant) == c) begin
        headData = f_data[c*DW +: DW];
        curSlot  = slot[c];
      end
    end
    for (int s = 0; s < NS; s++) begin
      if (int'(grant) == NF + s) begin
        headData = s_data[s*DW +: DW];
        sAddrSel = s_addr[s*AW +: AW];
      end
    end
    // fast channels interleave word-by-word within their packet slot
    fastAddr = AW'(int'(curSlot) * FRAME + int'(grant) + NF * int'(wordIdx));
  end

  always_comb begin
    f_rdack = '0;
    s_rdack = '0;
    for (int c = 0; c < NF; c++) f_rdack[c] = (state == ST_LOAD) && (int'(grant) == c);
    for (int s = 0; s < NS; s++) s_rdack[s] = (state == ST_LOAD) && (int'(grant) == NF + s);
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      rrPtr    <= '0;
      wordIdx  <= '0;
      guardCnt <= '0;
      wAddr    <= '0;
      orbWord  <= '0;
      WE       <= 1'b0;
      for (int c = 0; c < NF; c++) slot[c] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            grant <= pick;
            rrPtr <= (int'(pick) == NR - 1) ? '0 : pick + 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (isFast) begin
            wAddr   <= fastAddr;
            orbWord <= headData;
            WE      <= 1'b1;
            state   <= ST_WRITE;
          end else if (sAddrSel != '0) begin
            wAddr   <= sAddrSel;
            orbWord <= headData;
            WE      <= 1'b1;
            state   <= ST_WRITE;
          end else begin
            // address 0 marks a discarded slow entry
            guardCnt <= GCW'(GUARD - 1);
            state    <= ST_GUARD;
          end
        end
        ST_WRITE: begin
          WE    <= 1'b0;
          state <= ST_GAP;
        end
        ST_GAP: begin
          if (isFast && int'(wordIdx) < WORDS - 1) begin
            wordIdx <= wordIdx + 1'b1;
            state   <= ST_LOAD;
          end else begin
            if (isFast) begin
              wordIdx <= '0;
              for (int c = 0; c < NF; c++) begin
                if (int'(grant) == c)
                  slot[c] <= (int'(slot[c]) == PKTS - 1) ? '0 : slot[c] + 1'b1;
              end
            end
            guardCnt <= GCW'(GUARD - 1);
            state    <= ST_GUARD;
          end
        end
        ST_GUARD: begin
          if (guardCnt == '0) begin
            wAddr   <= '0;
            orbWord <= '0;
            state   <= ST_IDLE;
          end else begin
            guardCnt <= guardCnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_orb_frame_packer.sv
// Directed bench for orb_frame_packer: FIFO models feed the DUT, a negedge
// monitor logs writes and pops, and each task checks its scenario inline.
module tb_orb_frame_packer;
  localparam int NF = 2;
  localparam int NS = 2;
  localparam int DW = 12;
  localparam int AW = 11;
  localparam int UW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NF*UW-1:0] f_usedw;
  logic [NF*DW-1:0] f_data;
  logic [NF-1:0]    f_rdack;
  logic [NS-1:0]    s_empty;
  logic [NS*AW-1:0] s_addr;
  logic [NS*DW-1:0] s_data;
  logic [NS-1:0]    s_rdack;
  logic [AW-1:0]    wAddr;
  logic [DW-1:0]    orbWord;
  logic             WE;
  logic             busy;

  orb_frame_packer dut (
    .clk(clk), .rst(rst),
    .f_usedw(f_usedw), .f_data(f_data), .f_rdack(f_rdack),
    .s_empty(s_empty), .s_addr(s_addr), .s_data(s_data), .s_rdack(s_rdack),
    .wAddr(wAddr), .orbWord(orbWord), .WE(WE), .busy(busy)
  );

  int fPush [NF] = '{default: 0};
  int fPop  [NF] = '{default: 0};
  int sPush [NS] = '{default: 0};
  int sPop  [NS] = '{default: 0};
  logic [AW-1:0] sAddrV [NS] = '{default: '0};
  logic [DW-1:0] sDataV [NS] = '{default: '0};

  always_comb begin
    f_usedw = '0;
    f_data  = '0;
    s_empty = '0;
    s_addr  = '0;
    s_data  = '0;
    for (int c = 0; c < NF; c++) begin
      f_usedw[c*UW +: UW] = UW'(fPush[c] - fPop[c]);
      f_data[c*DW +: DW]  = DW'(c * 256 + fPop[c]);
    end
    for (int s = 0; s < NS; s++) begin
      s_empty[s]          = (sPush[s] == sPop[s]);
      s_addr[s*AW +: AW]  = sAddrV[s];
      s_data[s*DW +: DW]  = sDataV[s];
    end
  end

  always @(posedge clk) begin
    for (int c = 0; c < NF; c++) if (f_rdack[c]) fPop[c] <= fPop[c] + 1;
    for (int s = 0; s < NS; s++) if (s_rdack[s]) sPop[s] <= sPop[s] + 1;
  end

  logic [AW-1:0] weAddrQ [$];
  logic [DW-1:0] weDataQ [$];
  int rdF [NF] = '{default: 0};
  int rdS [NS] = '{default: 0};
  int multiRd = 0;

  always @(negedge clk) begin
    if (WE) begin
      weAddrQ.push_back(wAddr);
      weDataQ.push_back(orbWord);
    end
    for (int c = 0; c < NF; c++) if (f_rdack[c]) rdF[c] <= rdF[c] + 1;
    for (int s = 0; s < NS; s++) if (s_rdack[s]) rdS[s] <= rdS[s] + 1;
    if ($countones({f_rdack, s_rdack}) > 1) multiRd <= multiRd + 1;
  end

  int pass = 0;
  int total = 0;

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic runTxn(output int busyCyc);
    int t;
    busyCyc = 0;
    t = 0;
    while (!busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    while (busy && t < 3000) begin
      busyCyc++;
      @(negedge clk);
      t++;
    end
    total++;
    if (busyCyc == 0 || busy) $display("FAIL txn_bound busy_cycles=%0d still_busy=%0b", busyCyc, busy);
    else pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (WE !== 1'b0) $display("FAIL reset_we got=%0b exp=0", WE); else pass++;
    total++; if (wAddr !== '0) $display("FAIL reset_waddr got=%0h exp=0", wAddr); else pass++;
    total++; if (orbWord !== '0) $display("FAIL reset_word got=%0h exp=0", orbWord); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else pass++;
    total++; if ({f_rdack, s_rdack} !== '0) $display("FAIL reset_rdack got=%0h exp=0", {f_rdack, s_rdack}); else pass++;
    rst = 1'b0;
  endtask

  task automatic test_single_burst();
    int b0, r0, pop0, bc, n;
    b0 = weAddrQ.size(); r0 = rdF[0]; pop0 = fPop[0];
    fPush[0] += 16;
    runTxn(bc);
    n = weAddrQ.size() - b0;
    total++; if (bc != 80) $display("FAIL single_busy_cycles got=%0d exp=80", bc); else pass++;
    total++; if (n != 16) $display("FAIL single_we_count got=%0d exp=16", n); else pass++;
    total++; if (rdF[0] - r0 != 16) $display("FAIL single_rdack_count got=%0d exp=16", rdF[0] - r0); else pass++;
    if (n == 16) begin
      for (int k = 0; k < 16; k++) begin
        total++;
        if (weAddrQ[b0+k] !== AW'(2*k) || weDataQ[b0+k] !== DW'(pop0 + k))
          $display("FAIL single_word%0d got=%0h/%0h exp=%0h/%0h", k, weAddrQ[b0+k], weDataQ[b0+k], 2*k, pop0 + k);
        else pass++;
      end
    end
    total++; if (wAddr !== '0 || orbWord !== '0) $display("FAIL single_idle_out got=%0h/%0h exp=0/0", wAddr, orbWord); else pass++;
  endtask

  task automatic test_fast1_twice();
    int b0, pop1, bc, n;
    for (int b = 0; b < 2; b++) begin
      b0 = weAddrQ.size(); pop1 = fPop[1];
      fPush[1] += 16;
      runTxn(bc);
      n = weAddrQ.size() - b0;
      total++; if (n != 16) $display("FAIL fast1_count b%0d got=%0d exp=16", b, n); else pass++;
      if (n == 16) begin
        for (int k = 0; k < 16; k++) begin
          total++;
          if (weAddrQ[b0+k] !== AW'(32*b + 1 + 2*k) || weDataQ[b0+k] !== DW'(256 + pop1 + k))
            $display("FAIL fast1_b%0d_word%0d got=%0h/%0h exp=%0h/%0h", b, k, weAddrQ[b0+k], weDataQ[b0+k],
                     32*b + 1 + 2*k, 256 + pop1 + k);
          else pass++;
        end
      end
    end
  endtask

  task automatic test_arbitration();
    int b0, pop0, s0, bc, n;
    doReset();
    b0 = weAddrQ.size(); pop0 = fPop[0]; s0 = rdS[0];
    sAddrV[0] = 11'h155; sDataV[0] = 12'hABC;
    sPush[0]++;
    fPush[0] += 16;
    runTxn(bc);
    runTxn(bc);
    n = weAddrQ.size() - b0;
    total++; if (n != 17) $display("FAIL arb_count got=%0d exp=17", n); else pass++;
    if (n == 17) begin
      for (int k = 0; k < 16; k++) begin
        total++;
        if (weAddrQ[b0+k] !== AW'(2*k) || weDataQ[b0+k] !== DW'(pop0 + k))
          $display("FAIL arb_fast_word%0d got=%0h/%0h exp=%0h/%0h", k, weAddrQ[b0+k], weDataQ[b0+k], 2*k, pop0 + k);
        else pass++;
      end
      total++;
      if (weAddrQ[b0+16] !== 11'h155 || weDataQ[b0+16] !== 12'hABC)
        $display("FAIL arb_slow_word got=%0h/%0h exp=155/abc", weAddrQ[b0+16], weDataQ[b0+16]);
      else pass++;
    end
    total++; if (rdS[0] - s0 != 1) $display("FAIL arb_slow_rdack got=%0d exp=1", rdS[0] - s0); else pass++;
  endtask

  task automatic test_discard();
    int b0, s1, bc;
    b0 = weAddrQ.size(); s1 = rdS[1];
    sAddrV[1] = '0; sDataV[1] = 12'h777;
    sPush[1]++;
    runTxn(bc);
    total++; if (bc != 33) $display("FAIL discard_busy_cycles got=%0d exp=33", bc); else pass++;
    total++; if (weAddrQ.size() != b0) $display("FAIL discard_we got=%0d exp=0", weAddrQ.size() - b0); else pass++;
    total++; if (rdS[1] - s1 != 1) $display("FAIL discard_rdack got=%0d exp=1", rdS[1] - s1); else pass++;
    total++; if (s_empty[1] !== 1'b1) $display("FAIL discard_empty got=%0b exp=1", s_empty[1]); else pass++;
  endtask

  task automatic test_slot_wrap();
    int b0, bc;
    int firstAddr [65];
    doReset();
    for (int b = 0; b < 65; b++) begin
      b0 = weAddrQ.size();
      fPush[0] += 16;
      runTxn(bc);
      firstAddr[b] = (weAddrQ.size() > b0) ? int'(weAddrQ[b0]) : -1;
    end
    total++; if (firstAddr[0] != 0) $display("FAIL wrap_burst0 got=%0d exp=0", firstAddr[0]); else pass++;
    total++; if (firstAddr[1] != 32) $display("FAIL wrap_burst1 got=%0d exp=32", firstAddr[1]); else pass++;
    total++; if (firstAddr[63] != 2016) $display("FAIL wrap_burst63 got=%0d exp=2016", firstAddr[63]); else pass++;
    total++; if (firstAddr[64] != 0) $display("FAIL wrap_burst64 got=%0d exp=0", firstAddr[64]); else pass++;
  endtask

  task automatic test_reset_midburst();
    int b0, pop1, bc, n, t;
    doReset();
    b0 = weAddrQ.size();
    fPush[1] += 16;
    t = 0;
    while (!(f_rdack[1] && weAddrQ.size() - b0 == 7) && t < 300) begin
      @(negedge clk);
      t++;
    end
    total++; if (t >= 300) $display("FAIL midburst_reach_word7 got=timeout exp=word7"); else pass++;
    rst = 1'b1;
    @(negedge clk);
    total++; if (WE !== 1'b0) $display("FAIL midrst_we got=%0b exp=0", WE); else pass++;
    total++; if (wAddr !== '0) $display("FAIL midrst_waddr got=%0h exp=0", wAddr); else pass++;
    total++; if (orbWord !== '0) $display("FAIL midrst_word got=%0h exp=0", orbWord); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%0b exp=0", busy); else pass++;
    total++; if ({f_rdack, s_rdack} !== '0) $display("FAIL midrst_rdack got=%0h exp=0", {f_rdack, s_rdack}); else pass++;
    b0 = weAddrQ.size(); pop1 = fPop[1];
    rst = 1'b0;
    fPush[1] += 16;
    runTxn(bc);
    n = weAddrQ.size() - b0;
    total++; if (n != 16) $display("FAIL midrst_restart_count got=%0d exp=16", n); else pass++;
    if (n == 16) begin
      for (int k = 0; k < 16; k++) begin
        total++;
        if (weAddrQ[b0+k] !== AW'(1 + 2*k) || weDataQ[b0+k] !== DW'(256 + pop1 + k))
          $display("FAIL midrst_word%0d got=%0h/%0h exp=%0h/%0h", k, weAddrQ[b0+k], weDataQ[b0+k], 1 + 2*k, 256 + pop1 + k);
        else pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_fast1_twice();
    test_arbitration();
    test_discard();
    test_slot_wrap();
    test_reset_midburst();
    total++; if (multiRd != 0) $display("FAIL single_rdack_rule got=%0d exp=0", multiRd); else pass++;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
